// File: rtl/teclado_pkg.sv
// Shared definitions for the keypad scanner: FSM state encoding and the
// code-width helper used to size key indices.
package teclado_pkg;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    // Bits needed to index n items, never less than 1.
    function automatic int code_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for asynchronous inputs, width-parameterised.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/teclado_scan.sv
// Matrix keypad scanner: rotates a one-hot column drive, debounces press and
// release of the first key found, and conditions a separate enter button.
module teclado_scan
    import teclado_pkg::*;
#(
    parameter int  N_COL    = 4,
    parameter int  N_ROW    = 4,
    parameter int  SCAN_DIV = 4,
    parameter int  DEB_CNT  = 3,
    localparam int CODE_W   = code_w(N_ROW * N_COL)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_ROW-1:0]  fila,
    input  logic              enter,
    output logic [N_COL-1:0]  col,
    output logic [CODE_W-1:0] key_code,
    output logic              key_valid,
    output logic              key_down,
    output logic              enter_sync,
    output logic              enter_pulse
);
    localparam int         DIV_W   = code_w(SCAN_DIV);
    localparam int         ROW_W   = code_w(N_ROW);
    localparam int         COL_W   = code_w(N_COL);
    localparam logic [3:0] DEB_LIM = 4'(DEB_CNT);

    logic [N_ROW-1:0] fila_s;
    logic             enter_sync_d;
    logic [DIV_W-1:0] div_cnt;
    logic             strobe;
    state_t           state;
    logic [3:0]       deb_cnt;
    logic [ROW_W-1:0] row_q;
    logic [ROW_W-1:0] low_row;
    logic [COL_W-1:0] col_idx;
    logic [N_COL-1:0] col_rot;
    logic             row_hit;

    sync2 #(.W(N_ROW)) u_sync_fila (
        .clk (clk),
        .rst (rst),
        .d   (fila),
        .q   (fila_s)
    );

    sync2 #(.W(1)) u_sync_enter (
        .clk (clk),
        .rst (rst),
        .d   (enter),
        .q   (enter_sync)
    );

    assign strobe  = (div_cnt == DIV_W'(SCAN_DIV - 1));
    assign col_rot = {col[N_COL-2:0], col[N_COL-1]};

    // Lowest active row wins; column index decoded from the one-hot drive.
    always_comb begin
        low_row = '0;
        for (int i = N_ROW - 1; i >= 0; i--)
            if (fila_s[i]) low_row = ROW_W'(i);
        col_idx = '0;
        for (int j = 0; j < N_COL; j++)
            if (col[j]) col_idx = COL_W'(j);
        row_hit = 1'b0;
        for (int i = 0; i < N_ROW; i++)
            if (ROW_W'(i) == row_q) row_hit = fila_s[i];
    end

    always_ff @(posedge clk) begin
        if (rst || strobe) div_cnt <= '0;
        else               div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            enter_sync_d <= 1'b0;
            enter_pulse  <= 1'b0;
        end else begin
            enter_sync_d <= enter_sync;
            enter_pulse  <= enter_sync & ~enter_sync_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_SCAN;
            col       <= N_COL'(1);
            key_code  <= '0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
            deb_cnt   <= '0;
            row_q     <= '0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    if (strobe) begin
                        if (fila_s == '0) begin
                            col <= col_rot;
                        end else begin
                            row_q   <= low_row;
                            deb_cnt <= 4'd1;
                            state   <= (DEB_LIM == 4'd1) ? ST_PRESSED : ST_DEBOUNCE;
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if (strobe) begin
                        if (row_hit) begin
                            deb_cnt <= deb_cnt + 4'd1;
                            if (deb_cnt + 4'd1 >= DEB_LIM) state <= ST_PRESSED;
                        end else begin
                            col   <= col_rot;
                            state <= ST_SCAN;
                        end
                    end
                end
                ST_PRESSED: begin
                    key_code  <= CODE_W'(int'(row_q) * N_COL + int'(col_idx));
                    key_valid <= 1'b1;
                    key_down  <= 1'b1;
                    deb_cnt   <= '0;
                    state     <= ST_RELEASE;
                end
                ST_RELEASE: begin
                    // Any activity on the held column restarts the release count.
                    if (strobe) begin
                        if (fila_s != '0) begin
                            deb_cnt <= '0;
                        end else if (deb_cnt + 4'd1 >= DEB_LIM) begin
                            key_down <= 1'b0;
                            col      <= col_rot;
                            deb_cnt  <= '0;
                            state    <= ST_SCAN;
                        end else begin
                            deb_cnt <= deb_cnt + 4'd1;
                        end
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: doc/teclado_scan.md
TECLADO_SCAN -- requirements
Module: teclado_scan

Interface
REQ-001 Parameter N_COL, default 4, number of keypad columns (2..8).
REQ-002 Parameter N_ROW, default 4, number of keypad rows (2..8).
REQ-003 Parameter SCAN_DIV, default 4, clk cycles per scan strobe (>=3).
REQ-004 Parameter DEB_CNT, default 3, consecutive agreeing strobes required to accept a press or a release (1..15).
REQ-005 Derived constant CODE_W = clog2(N_ROW*N_COL), minimum 1.
REQ-006 clk  input  1  single system clock; all logic on its rising edge.
REQ-007 rst  input  1  synchronous, active-high reset.
REQ-008 fila  input  N_ROW  raw row lines, bit=1 means a key in that row connects to the driven column.
REQ-009 enter  input  1  raw asynchronous enter button.
REQ-010 col  output  N_COL  one-hot column drive.
REQ-011 key_code  output  CODE_W  index of the accepted key = row*N_COL + column.
REQ-012 key_valid  output  1  one-cycle pulse when a press is accepted.
REQ-013 key_down  output  1  high from acceptance until the release is accepted.
REQ-014 enter_sync  output  1  synchronised enter level.
REQ-015 enter_pulse  output  1  one-cycle pulse on the enter_sync rising edge.

Function
REQ-016 fila and enter each pass through a 2-flop synchroniser; fila_s and enter_sync are the second-stage values.
REQ-017 A divider counts 0..SCAN_DIV-1 and asserts strobe for one cycle when it reaches SCAN_DIV-1, then wraps to 0.
REQ-018 The FSM has states SCAN, DEBOUNCE, PRESSED and RELEASE, and acts only on strobe cycles, except in PRESSED.
REQ-019 SCAN, strobe with fila_s==0: col rotates left one position, wrapping from bit N_COL-1 to bit 0.
REQ-020 SCAN, strobe with fila_s!=0: col is held, the lowest set row index is captured, deb_cnt is set to 1, and the FSM enters DEBOUNCE.
REQ-021 DEBOUNCE, strobe with the captured row bit set: deb_cnt increments; when deb_cnt reaches DEB_CNT, the FSM enters PRESSED on that edge.
REQ-022 DEBOUNCE, strobe with the captured row bit clear: the press is abandoned, col rotates one position, and the FSM enters SCAN; no key_valid is produced.
REQ-023 PRESSED lasts exactly one cycle and performs three actions: key_code <= row*N_COL + col index, key_valid = 1, and key_down <= 1; the FSM then enters RELEASE with deb_cnt = 0.
REQ-024 RELEASE, strobe with fila_s==0: deb_cnt increments.
REQ-025 RELEASE, strobe with fila_s!=0: deb_cnt resets to 0.
REQ-026 When deb_cnt reaches DEB_CNT in RELEASE: key_down <= 0, col rotates one position, and the FSM enters SCAN.
REQ-027 Other keys pressed while in DEBOUNCE or RELEASE are ignored; there is no rollover.
REQ-028 If DEB_CNT == 1, a single agreeing strobe is sufficient.
REQ-029 key_code holds its last accepted value until the next acceptance.
REQ-030 enter_pulse = enter_sync & ~enter_sync_d, where enter_sync_d is enter_sync delayed one cycle; the enter path is independent of the FSM.
REQ-031 col is always one-hot, with no all-zero or multi-hot state, including across reset.

Reset
REQ-032 On rst=1 at a clk edge, the following take their reset values: col = 1 (column 0), key_code = 0, key_valid = 0, key_down = 0, enter_sync = 0, enter_pulse = 0.
REQ-033 On the same edge, internal state resets: FSM = SCAN, divider = 0, deb_cnt = 0, and both synchroniser stages = 0.
REQ-034 Reset asserted mid-press, in any state, aborts the press without a key_valid pulse; after release of reset, scanning restarts from column 0.

Structure
REQ-035 A shared package teclado_pkg holds the FSM state encoding and the CODE_W calculation function.
REQ-036 One sub-module, sync2 (2-flop synchroniser with a width parameter), is instantiated for fila and for enter.

Verification
All scenarios use N_COL=4, N_ROW=4, SCAN_DIV=4, DEB_CNT=3.
REQ-037 Reset test: hold rst for 2 cycles -> col=4'b0001 and all other outputs 0; then col=0010, 0100, 1000, 0001 on successive strobes (every 4 clk).
REQ-038 Single key test: assert fila=4'b0010 only while col=4'b0100, held stable -> exactly one key_valid, with key_code=6; key_down stays high until 3 strobes after fila returns to 0.
REQ-039 Bounce test: fila at row 0, column 1 is high for 1 strobe then low -> no key_valid, and scanning resumes at col=4'b0100.
REQ-040 Multi-row test: fila=4'b1010 while col=4'b0001 -> key_code=4 (lowest row wins); a second key pressed during RELEASE produces no pulse.
REQ-041 Release bounce test: during RELEASE, fila toggles 0,0,1,0,0,0 over successive strobes -> key_down falls only after the final three zeros.
REQ-042 Enter/reset test: enter rises -> enter_pulse is high for exactly 1 cycle, 3 cycles after the input change; rst asserted in DEBOUNCE -> no key_valid, and col=4'b0001.
